// File: rtl/serial_frame_rx_pkg.sv
// Shared types and helpers for the serial frame receiver: FSM state encoding,
// bit-counter sizing and the even-parity check.
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int MAX_WIDTH = 32;

  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

  // 1 when the data bits together with the parity bit hold an even number of ones.
  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] word, input logic par_bit);
    return ~((^word) ^ par_bit);
  endfunction

endpackage

// File: rtl/rx_hold_reg.sv
// One-entry valid/ready holding register for received words; a load that finds
// the register full and not draining is dropped and reported as an overrun.
module rx_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load) begin
      // A draining register accepts the new word on the same edge as the transfer.
      if (!valid_q || out_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, optional even
// parity, stop bit of 0; good words go to a one-entry valid/ready register.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = cnt_bits(WIDTH);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             load;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    load         = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (serial_in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = {serial_in, shift_q[WIDTH-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_d   = serial_in;
          state_d = STOP;
        end
        STOP: begin
          // A bad stop bit wins over a bad parity bit so only one error fires.
          state_d = IDLE;
          if (serial_in) begin
            frame_err_d = 1'b1;
          end else if ((PARITY_EN != 0) && !even_parity(MAX_WIDTH'(shift_q), par_q)) begin
            parity_err_d = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  rx_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .word      (shift_q),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Receive-side counterpart of the team's parallel-to-serial shifter. Sits directly downstream of it on the same clock and consumes its one-bit-per-cycle, LSB-first stream.
- Detects a start bit, then deserialises WIDTH data bits, an optional even-parity bit and a stop bit.
- Presents each good word on a valid/ready output port with a one-entry holding register.

Parameters:
WIDTH, 4, data bits per frame (2..32).
PARITY_EN, 1, 1 = even-parity bit follows the data bits; 0 = no parity bit.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset, synchronous to clk and active-low.
serial_in  input  1  serial line; idle level 0, LSB first.
bit_en  input  1  1 = sample serial_in this cycle; 0 = all FSM state holds.
data_out  output  WIDTH  received word, stable while out_valid=1.
out_valid  output  1  holding register contains an unconsumed word.
out_ready  input  1  consumer accepts; a transfer occurs when out_valid and out_ready are both 1.
parity_err  output  1  one-cycle pulse: frame dropped because of a parity mismatch.
frame_err  output  1  one-cycle pulse: frame dropped because the stop bit was 1.
overrun  output  1  one-cycle pulse: good frame dropped because the holding register was full.
busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; data_out=0; out_valid=0; parity_err=0; frame_err=0; overrun=0; busy=0; shift register and bit counter cleared.
  - Reset mid-frame aborts the frame silently and discards any held word.
- FSM states: IDLE, DATA, PARITY, STOP. The FSM advances only on cycles with bit_en=1.
- IDLE: serial_in=1 is the start bit; go to DATA with the counter cleared. serial_in=0 stays in IDLE.
- DATA:
  - Shift serial_in into the MSB of the shift register, with the existing contents moving right. After WIDTH samples, bit 0 holds the first-received bit.
  - Increment the counter. After the WIDTH-th sample go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: capture serial_in as the parity bit, then go to STOP. Required: XOR of the data bits and the parity bit = 0.
- STOP: sample serial_in, then return to IDLE. The stop-sample cycle never counts as a start bit.
  - Stop bit = 1: frame_err pulses next cycle; word dropped. frame_err takes precedence over parity_err; only one error pulses per frame.
  - Stop bit = 0 and parity bad: parity_err pulses next cycle; word dropped.
  - Stop bit = 0, parity good, and (out_valid=0 or out_ready=1 this cycle): next cycle data_out=word and out_valid=1.
  - Stop bit = 0, parity good, and out_valid=1 with out_ready=0: held word kept unchanged; overrun pulses next cycle; new word dropped.
- Latency: out_valid rises exactly one cycle after the stop-bit sample.
- Back-to-back frames: a start bit may be sampled on the cycle immediately after the stop sample, giving a minimum frame of WIDTH+2+PARITY_EN bit times.
- Output handshake:
  - out_valid clears the cycle after a transfer unless a new word loads on that same edge; a simultaneous transfer and load gives back-to-back valid data.
  - data_out changes only on a load.
- busy=1 in DATA, PARITY and STOP.
- bit_en=0 with out_ready=1 still completes a pending transfer.

Decomposition:
- Shared package: state enum {IDLE, DATA, PARITY, STOP}; even_parity function; bit-counter width constant $clog2(WIDTH+1).
- One sub-module, rx_hold_reg: the one-entry valid/ready holding register. It takes a load strobe and the word, and drives data_out, out_valid and an overrun strobe.

Test Plan:
1. WIDTH=4, PARITY_EN=1, bit_en=1; serial_in 1,1,1,0,1,1,0 on cycles 0-6 with out_ready=1 -> at cycle 7 data_out=4'hB and out_valid=1 for exactly one cycle; no error pulses.
2. Same frame with the parity bit flipped to 0 -> parity_err pulses at cycle 7; out_valid stays 0; FSM in IDLE at cycle 7.
3. Same frame with the stop bit = 1 -> frame_err pulses at cycle 7 (not parity_err); the stop 1 is not taken as a start; the next real frame is received correctly.
4. Two back-to-back frames 4'hB then 4'h4 with out_ready=0 -> first word held at 4'hB; overrun pulses one cycle after the second stop bit; data_out remains 4'hB; raising out_ready gives one transfer, then out_valid=0.
5. Frame 4'hB with bit_en toggling 1,0,1,0… -> same result as scenario 1, with out_valid rising one cycle after the stop-bit sample cycle.
6. rst=0 asserted for one cycle after the second data bit, then frame 4'h5 sent -> all outputs 0 in the cycle after reset; the partial frame is never delivered; data_out=4'h5 delivered correctly.
